// File: rtl/cmp_stream_pkg.sv
// rtl/cmp_stream_pkg.sv - shared types and limits for the comparator stream serializer
// Provides the serializer FSM state encoding and the widest supported operand.

package cmp_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SHIFT = 2'd2
    } cmp_tx_state_t;

    localparam int CMP_TX_MAX_WIDTH = 32;

endpackage

// File: rtl/cmp_tx_shreg.sv
// rtl/cmp_tx_shreg.sv - parallel-load left-shift register exposing its MSB
// Ports:
//   clk, reset (async, active-low)
//   load  - capture din (takes priority over shift)
//   shift - shift left by one, filling with 0
//   din   - parallel operand
//   msb   - current most significant bit

module cmp_tx_shreg
    import cmp_stream_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);

    logic [WIDTH-1:0] q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= {q[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = q[WIDTH-1];

endmodule

// File: rtl/comparator_stream_tx.sv
// rtl/comparator_stream_tx.sv - MSB-first bit-pair serializer for the bit-serial comparator
// Accepts an operand pair on a valid/ready handshake, emits a one-cycle active-low
// clear (frame_n), then streams a_bit/b_bit one pair per clock with bit_valid/last.
// Ports:
//   clk, reset (async, active-low)
//   in_valid, in_ready, a_word, b_word - operand handshake
//   frame_n                           - comparator clear, low one cycle per frame
//   a_bit, b_bit, bit_valid, last     - serial stream
//   busy                              - frame in progress
// Optional build macro: CMP_TX_EARLY_STOP_EN - end the frame on the first differing pair.

module comparator_stream_tx
    import cmp_stream_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_word,
    input  logic [WIDTH-1:0] b_word,
    output logic             frame_n,
    output logic             a_bit,
    output logic             b_bit,
    output logic             bit_valid,
    output logic             last,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    cmp_tx_state_t    state;
    logic [CNT_W-1:0] cnt;
    logic             a_msb;
    logic             b_msb;
    logic             in_shift;
    logic             frame_end;
    logic             handshake;

    assign in_shift = (state == SHIFT);

`ifdef CMP_TX_EARLY_STOP_EN
    // The first differing pair already decides the comparison, so the frame stops there.
    assign frame_end = in_shift && ((cnt == '0) || (a_msb != b_msb));
`else
    assign frame_end = in_shift && (cnt == '0);
`endif

    // Accepting on the final bit lets the next frame's CLEAR follow with no idle gap.
    assign in_ready  = (state == IDLE) || frame_end;
    assign handshake = in_valid && in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        state <= CLEAR;
                        cnt   <= CNT_W'(WIDTH - 1);
                    end
                end
                CLEAR: begin
                    state <= SHIFT;
                end
                SHIFT: begin
                    if (frame_end) begin
                        if (handshake) begin
                            state <= CLEAR;
                            cnt   <= CNT_W'(WIDTH - 1);
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    cmp_tx_shreg #(.WIDTH(WIDTH)) u_shreg_a (
        .clk   (clk),
        .reset (reset),
        .load  (handshake),
        .shift (in_shift),
        .din   (a_word),
        .msb   (a_msb)
    );

    cmp_tx_shreg #(.WIDTH(WIDTH)) u_shreg_b (
        .clk   (clk),
        .reset (reset),
        .load  (handshake),
        .shift (in_shift),
        .din   (b_word),
        .msb   (b_msb)
    );

    // Outputs decode only from registered state, counter and register MSBs.
    assign frame_n   = (state != CLEAR);
    assign bit_valid = in_shift;
    assign a_bit     = in_shift & a_msb;
    assign b_bit     = in_shift & b_msb;
    assign last      = frame_end;
    assign busy      = (state != IDLE);

endmodule
